// File: rtl/yapp_nrouter_pkg.sv
// yapp_nrouter_pkg: shared definitions for the parametrised YAPP router.
//   state_t   : input FSM states
//   LEN_MSB / LEN_LSB / ADDR_W : header field positions {len[7:2], addr[1:0]}
//   hdr_good  : header acceptance test (addr in range, 1 <= len <= max_len)
package yapp_nrouter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_W  = 2;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    function automatic logic hdr_good(input logic [7:0] hdr,
                                      input int         num_ch,
                                      input int         max_len);
        int len;
        int addr;
        len  = int'(hdr[LEN_MSB:LEN_LSB]);
        addr = int'(hdr[ADDR_W-1:0]);
        return (addr < num_ch) && (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/yapp_fifo.sv
// yapp_fifo: synchronous single-clock byte FIFO.
//   clock, reset (async, active-low)
//   wr_en/wr_data : push (ignored when full)
//   rd_en/rd_data : pop (ignored when empty); rd_data shows the head entry
//   count/full/empty : occupancy; count is one bit wider than the pointers
//                      so full and empty are unambiguous
module yapp_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/yapp_nrouter.sv
// yapp_nrouter: YAPP packet router with NUM_CH cut-through output channels.
//   clock, reset (async, active-low)
//   in_data/in_data_vld : input byte stream; in_suspend : registered backpressure
//   out_data[8c+7:8c], out_data_vld[c], out_suspend[c] : output channel c
//   error : one-cycle pulse per dropped header or parity mismatch
//   pkt_cnt/drop_cnt/perr_cnt : saturating statistics, built only when
//   YAPP_NROUTER_STATS_EN is defined (otherwise tied to 0)
module yapp_nrouter
    import yapp_nrouter_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 63
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_data_vld,
    output logic                in_suspend,
    output logic [NUM_CH*8-1:0] out_data,
    output logic [NUM_CH-1:0]   out_data_vld,
    input  logic [NUM_CH-1:0]   out_suspend,
    output logic                error,
    output logic [15:0]         pkt_cnt,
    output logic [15:0]         drop_cnt,
    output logic [15:0]         perr_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W:0] REM_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W:0]    rem_q;      // bytes still expected in PAYLOAD / DROP
    logic [7:0]        par_q;

    logic              accept;
    logic              hdr_ok;
    logic [LEN_W-1:0]  hdr_len;
    logic [ADDR_W-1:0] hdr_addr;
    logic              wr_any;
    logic [ADDR_W-1:0] wr_addr;
    logic              susp_nxt;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] f_full;
    logic [NUM_CH-1:0] f_empty;
    logic [7:0]        f_dout [NUM_CH];
    logic [CNT_W-1:0]  f_cnt  [NUM_CH];
    logic [7:0]        od_q   [NUM_CH];

    assign accept   = in_data_vld && !in_suspend;
    assign hdr_ok   = hdr_good(in_data, NUM_CH, MAX_LEN);
    assign hdr_len  = in_data[LEN_MSB:LEN_LSB];
    assign hdr_addr = in_data[ADDR_W-1:0];

    // Write steering and suspend look-ahead. Suspend is decided on the
    // occupancy each FIFO will hold after this edge, so the sender sees it
    // one cycle later while at least one free slot still remains.
    always_comb begin
        int n;
        n        = 0;
        wr_any   = 1'b0;
        wr_addr  = addr_q;
        susp_nxt = 1'b0;
        case (state)
            IDLE: begin
                wr_any  = accept && hdr_ok;
                wr_addr = hdr_addr;
            end
            PAYLOAD, PARITY: wr_any = accept;
            default: wr_any = 1'b0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            push[c] = wr_any && (wr_addr == ADDR_W'(c)) && !f_full[c];
            pop[c]  = !f_empty[c] && !out_suspend[c];
            n = int'(f_cnt[c]) + int'(push[c]) - int'(pop[c]);
            if (n >= FIFO_DEPTH - 1) susp_nxt = 1'b1;
        end
    end

`ifdef YAPP_NROUTER_STATS_EN
    logic [15:0] pkt_q;
    logic [15:0] drop_q;
    logic [15:0] perr_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
    assign perr_cnt = perr_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
    assign perr_cnt = '0;
`endif

    // Input FSM: header decode, payload count, parity check, drop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            error      <= 1'b0;
            in_suspend <= 1'b0;
`ifdef YAPP_NROUTER_STATS_EN
            pkt_q      <= '0;
            drop_q     <= '0;
            perr_q     <= '0;
`endif
        end else begin
            error      <= 1'b0;
            in_suspend <= susp_nxt;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (hdr_ok) begin
                            addr_q <= hdr_addr;
                            rem_q  <= {1'b0, hdr_len};
                            state  <= PAYLOAD;
                        end else begin
                            // len payload bytes plus the parity byte
                            error  <= 1'b1;
                            rem_q  <= {1'b0, hdr_len} + REM_ONE;
                            state  <= DROP;
`ifdef YAPP_NROUTER_STATS_EN
                            drop_q <= sat_inc(drop_q);
`endif
                        end
                    end
                    PAYLOAD: begin
                        rem_q <= rem_q - REM_ONE;
                        if (rem_q == REM_ONE) state <= PARITY;
                    end
                    PARITY: begin
                        state <= IDLE;
                        if (in_data != par_q) begin
                            error  <= 1'b1;
`ifdef YAPP_NROUTER_STATS_EN
                            perr_q <= sat_inc(perr_q);
                        end else begin
                            pkt_q  <= sat_inc(pkt_q);
`endif
                        end
                    end
                    default: begin
                        rem_q <= rem_q - REM_ONE;
                        if (rem_q == REM_ONE) state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Parity accumulator is pure datapath; it is always re-seeded by a header.
    always_ff @(posedge clock) begin
        if (accept) begin
            if (state == IDLE)         par_q <= in_data;
            else if (state == PAYLOAD) par_q <= par_q ^ in_data;
        end
    end

    // Output channel registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data_vld <= '0;
            for (int c = 0; c < NUM_CH; c++) od_q[c] <= '0;
        end else begin
            out_data_vld <= pop;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pop[c]) od_q[c] <= f_dout[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign out_data[8*c +: 8] = od_q[c];

        yapp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (push[c]),
            .wr_data (in_data),
            .rd_en   (pop[c]),
            .rd_data (f_dout[c]),
            .count   (f_cnt[c]),
            .full    (f_full[c]),
            .empty   (f_empty[c])
        );
    end

endmodule

// File: doc/yapp_nrouter.md
# yapp_nrouter

- Parametrised YAPP packet router that succeeds the fixed three-channel router.
- Accepts one YAPP byte stream and checks each header. Valid packets are forwarded cut-through into a per-channel byte FIFO; bad packets are dropped and flagged.
- Sits between the YAPP input interface and NUM_CH output channels, each with its own suspend flow control.
- Checks packet parity and reports per-packet errors.

## Interface
- NUM_CH, 3: number of output channels, 1..4; header address is 2 bits.
- FIFO_DEPTH, 16: bytes per channel FIFO, power of two, >= 4.
- MAX_LEN, 63: largest accepted payload length, 1..63.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- in_data  input  8  YAPP byte.
- in_data_vld  input  1  byte valid.
- in_suspend  output  1  registered backpressure to the sender.
- out_data  output  NUM_CH*8  channel c data in bits [8c+7:8c].
- out_data_vld  output  NUM_CH  channel byte valid.
- out_suspend  input  NUM_CH  channel sink stall.
- error  output  1  one-cycle pulse per bad packet.
- pkt_cnt, drop_cnt, perr_cnt  output  16 each  statistics; see Configuration.

## Operation
- Packet format: header {len[7:2], addr[1:0]}, then len payload bytes, then a parity byte equal to the XOR of the header and all payload bytes.
- A byte is accepted on an edge where in_data_vld=1 and in_suspend=0. Bytes with in_data_vld=0 are ignored; gaps between bytes are legal.
- Input FSM states: IDLE, PAYLOAD, PARITY, DROP.
  - IDLE: an accepted byte is the header.
    - Good header (addr<NUM_CH and 1<=len<=MAX_LEN): write the header to FIFO[addr], latch addr and len, seed the parity accumulator, go to PAYLOAD.
    - Bad header: pulse error, latch len, go to DROP.
  - PAYLOAD: each accepted byte is written to FIFO[addr] and XORed into the accumulator. After the len-th byte, go to PARITY.
  - PARITY: the accepted byte is written to FIFO[addr]. If it mismatches the accumulator, pulse error. Return to IDLE.
  - DROP: consume len+1 further bytes without writing, then return to IDLE. A bad header with len=0 consumes only the parity byte.
- Parity errors do not recall data already forwarded; the packet is delivered intact including the wrong parity byte.
- in_suspend is a register. It is set when any channel FIFO ends the cycle with fewer than 2 free entries, otherwise cleared. The 2-entry margin covers the register delay, so no FIFO ever overflows.
- Channel output c: on each edge, if FIFO[c] is non-empty and out_suspend[c]=0, pop one byte into out_data[c] and set out_data_vld[c]=1; otherwise set out_data_vld[c]=0. out_data holds its last value while invalid.
- Channels drain independently.
- Simultaneous push and pop on the same FIFO in one cycle is legal; count is unchanged.

## Timing
- Reset values: in_suspend=0, out_data=0, out_data_vld=0, error=0, all counters 0, FSM=IDLE, all FIFOs empty.
- Latency: a byte accepted at edge N appears on out_data at edge N+1 at the earliest, provided the FIFO was empty and the channel is not suspended.
- error is asserted for exactly the cycle after the offending byte's edge.
- Reset mid-packet: FSM returns to IDLE and all FIFOs clear immediately. Partial packets are lost and not counted.
- FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by a count register of $clog2(FIFO_DEPTH)+1 bits.

## Configuration
- YAPP_NROUTER_STATS_EN defined:
  - pkt_cnt counts packets completed with good parity.
  - drop_cnt counts dropped headers.
  - perr_cnt counts parity mismatches.
  - Each counter is 16-bit, saturates at 0xFFFF, and increments on the same edge the error pulse (or packet completion) is decided.
- Macro undefined: counters are not built; the three ports are tied to 0.

## Structure
- yapp_nrouter_pkg holds the FSM state enum, the header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_W=2), and a header-decode function.
- Sub-module yapp_fifo: synchronous single-clock byte FIFO. Parameter DEPTH; outputs count, full, empty; instantiated NUM_CH times via generate.

## Test plan
- Header 0x0D (len 3, addr 1), payload 0x11 0x22 0x33, parity 0x0D^0x11^0x22^0x33=0x0D -> out channel 1 emits 0x0D 0x11 0x22 0x33 0x0D; error stays 0; pkt_cnt=1.
- Same packet with parity 0x00 -> all 5 bytes are delivered; error pulses once; perr_cnt=1.
- NUM_CH=3, header 0x07 (len 1, addr 3) plus 2 bytes -> nothing is written; error pulses once; drop_cnt=1; the next good packet routes normally.
- out_suspend[0]=1 while 20 bytes are streamed to addr 0, FIFO_DEPTH=16 -> in_suspend rises when FIFO[0] reaches 15 entries; no overflow. Releasing out_suspend drains every byte in order.
- Reset driven low after the 2nd payload byte of a len-5 packet -> all outputs return to reset values; the first post-reset byte is decoded as a header.
- Back-to-back packets to channels 0 and 2 with channel 0 suspended -> channel 2 delivers without waiting for channel 0.
